// File: rtl/bn_pkg.sv
// bn_pkg: shared widths and the round-half-away/saturate helper for the BN stage
package bn_pkg;
  localparam int QUANT_W_DEF = 16;
  typedef struct packed {
    logic signed [31:0] value;
    logic               sat;
  } rs_t;
  function automatic int sum_w(input int wd, input int wa, input int wb);
    return (wd + wa > wb + 1) ? wd + wa : wb + 1;
  endfunction
  function automatic rs_t round_sat(input logic signed [63:0] sum, input int qw, input int wo);
    logic [63:0] mag, q;
    logic signed [64:0] sq, hi, lo;
    rs_t r;
    mag = sum[63] ? 64'(-sum) : 64'(sum);
    q = (mag >> qw) + ((mag >> (qw - 1)) & 64'd1);
    sq = sum[63] ? -$signed({1'b0, q}) : $signed({1'b0, q});
    hi = (65'sd1 <<< (wo - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (wo - 1));
    r.sat = (sq > hi) || (sq < lo);
    r.value = 32'((sq > hi) ? hi : (sq < lo) ? lo : sq);
    return r;
  endfunction
endpackage

// File: rtl/bn_coef_bank.sv
// bn_coef_bank: per-channel scale/bias registers, sync write, async read
module bn_coef_bank
  import bn_pkg::*;
#(
  parameter int CH_NUM  = 4,
  parameter int CH_W    = 2,
  parameter int WIDTH_A = 18,
  parameter int WIDTH_B = 32
) (
  input  logic                      i_sclk,
  input  logic                      i_rstn,
  input  logic                      i_we,
  input  logic [CH_W-1:0]           i_waddr,
  input  logic signed [WIDTH_A-1:0] i_wa,
  input  logic signed [WIDTH_B-1:0] i_wb,
  input  logic [CH_W-1:0]           i_raddr,
  output logic signed [WIDTH_A-1:0] o_ra,
  output logic signed [WIDTH_B-1:0] o_rb
);
  localparam int DEPTH = 1 << CH_W;
  logic signed [WIDTH_A-1:0] a_mem [DEPTH];
  logic signed [WIDTH_B-1:0] b_mem [DEPTH];
  // coefficient writes; entries beyond CH_NUM are never written and stay zero
  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
      end
    end else if (i_we && 32'(i_waddr) < CH_NUM) begin
      a_mem[i_waddr] <= i_wa;
      b_mem[i_waddr] <= i_wb;
    end
  end
  assign o_ra = a_mem[i_raddr];
  assign o_rb = b_mem[i_raddr];
endmodule

// File: rtl/bn_act_quant_mc.sv
// bn_act_quant_mc: 3-stage per-channel scale/bias, round, saturate and ReLU with sideband delay
module bn_act_quant_mc
  import bn_pkg::*;
#(
  parameter int WIDTH_D = 29,
  parameter int WIDTH_A = 18,
  parameter int WIDTH_B = 32,
  parameter int WIDTH_O = 10,
  parameter int QUANT_W = QUANT_W_DEF,
  parameter int CH_NUM  = 4,
  parameter int CH_W    = 2
) (
  input  logic                      i_sclk,
  input  logic                      i_rstn,
  input  logic                      i_vsync,
  input  logic                      i_hsync,
  input  logic                      i_reuse,
  input  logic                      i_valid,
  input  logic signed [WIDTH_D-1:0] i_tdata,
  input  logic                      i_relu_en,
  input  logic                      i_cfg_we,
  input  logic [CH_W-1:0]           i_cfg_addr,
  input  logic signed [WIDTH_A-1:0] i_cfg_a,
  input  logic signed [WIDTH_B-1:0] i_cfg_b,
  output logic                      o_vsync,
  output logic                      o_hsync,
  output logic                      o_reuse,
  output logic                      o_valid,
  output logic signed [WIDTH_O-1:0] o_tdata,
  output logic                      o_sat,
  output logic [CH_W-1:0]           o_ch
);
  localparam int MW = WIDTH_D + WIDTH_A;
  localparam int SW = sum_w(WIDTH_D, WIDTH_A, WIDTH_B);
  logic [CH_W-1:0] ch, cur_ch, ch1, ch2;
  logic signed [WIDTH_A-1:0] ca;
  logic signed [WIDTH_B-1:0] cb, b1;
  logic signed [MW-1:0] m1;
  logic signed [SW-1:0] s2;
  logic [3:0] sb1, sb2;
  logic relu1, relu2, kill;
  rs_t rs;
  assign cur_ch = i_vsync ? '0 : ch;
  bn_coef_bank #(
    .CH_NUM (CH_NUM),
    .CH_W   (CH_W),
    .WIDTH_A(WIDTH_A),
    .WIDTH_B(WIDTH_B)
  ) u_bank (
    .i_sclk (i_sclk),
    .i_rstn (i_rstn),
    .i_we   (i_cfg_we),
    .i_waddr(i_cfg_addr),
    .i_wa   (i_cfg_a),
    .i_wb   (i_cfg_b),
    .i_raddr(cur_ch),
    .o_ra   (ca),
    .o_rb   (cb)
  );
  // channel counter: vsync restarts at 0, each valid sample advances with wrap
  always_ff @(posedge i_sclk) begin
    if (!i_rstn) ch <= '0;
    else if (i_valid) ch <= (cur_ch == CH_W'(CH_NUM - 1)) ? '0 : cur_ch + CH_W'(1);
    else if (i_vsync) ch <= '0;
  end
  // DSP datapath: product then bias add, valid-gated and left unreset
  always_ff @(posedge i_sclk) begin
    if (i_valid) begin
      m1 <= MW'(i_tdata) * MW'(ca);
      b1 <= cb;
    end
    if (sb1[0]) s2 <= SW'(m1) + SW'(b1);
  end
  // rounding, clamping and ReLU on the final sum
  always_comb begin
    rs = round_sat(64'(s2), QUANT_W, WIDTH_O);
    kill = relu2 & rs.value[31];
  end
  // sideband/control pipeline and registered outputs
  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      sb1 <= '0;
      sb2 <= '0;
      ch1 <= '0;
      ch2 <= '0;
      relu1 <= 1'b0;
      relu2 <= 1'b0;
      {o_vsync, o_hsync, o_reuse, o_valid} <= '0;
      o_tdata <= '0;
      o_sat <= 1'b0;
      o_ch <= '0;
    end else begin
      sb1 <= {i_vsync, i_hsync, i_reuse, i_valid};
      sb2 <= sb1;
      ch1 <= cur_ch;
      ch2 <= ch1;
      relu1 <= i_relu_en;
      relu2 <= relu1;
      {o_vsync, o_hsync, o_reuse, o_valid} <= sb2;
      o_ch <= ch2;
      o_sat <= sb2[0] & ~kill & rs.sat;
      if (sb2[0]) o_tdata <= kill ? '0 : rs.value[WIDTH_O-1:0];
    end
  end
endmodule

// File: tb/tb_bn_act_quant_mc.sv
// tb_bn_act_quant_mc: scoreboard bench for the BN/activation/quantisation stage
module tb_bn_act_quant_mc;
  logic i_sclk = 1'b0, i_rstn = 1'b0;
  logic i_vsync = 1'b0, i_hsync = 1'b0, i_reuse = 1'b0, i_valid = 1'b0, i_relu_en = 1'b0;
  logic signed [28:0] i_tdata = '0;
  logic i_cfg_we = 1'b0;
  logic [1:0] i_cfg_addr = '0;
  logic signed [19:0] i_cfg_a = '0;
  logic signed [31:0] i_cfg_b = '0;
  logic o_vsync, o_hsync, o_reuse, o_valid, o_sat;
  logic signed [9:0] o_tdata;
  logic [1:0] o_ch;
  typedef struct {
    logic signed [9:0] d;
    logic s;
    logic [1:0] ch;
    logic vs, hs, ru;
    int due;
  } exp_t;
  exp_t q[$];
  int cyc = 0, n_tests = 0, n_fail = 0, mch = 0;
  logic signed [9:0] last = '0;
  longint ma[4], mb[4];
  // scale width widened to 20 so (ch+1)*65536 up to 4.0 is representable
  bn_act_quant_mc #(.WIDTH_A(20)) dut (
    .i_sclk(i_sclk), .i_rstn(i_rstn), .i_vsync(i_vsync), .i_hsync(i_hsync),
    .i_reuse(i_reuse), .i_valid(i_valid), .i_tdata(i_tdata), .i_relu_en(i_relu_en),
    .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_a(i_cfg_a), .i_cfg_b(i_cfg_b),
    .o_vsync(o_vsync), .o_hsync(o_hsync), .o_reuse(o_reuse), .o_valid(o_valid),
    .o_tdata(o_tdata), .o_sat(o_sat), .o_ch(o_ch)
  );
  always #5 i_sclk = ~i_sclk;
  task automatic step(input bit rst_n, input bit vld, input longint x, input bit relu, input bit vs,
                      input bit hs, input bit ru, input bit we, input int addr, input longint wa, input longint wb);
    exp_t e;
    int cur;
    longint p, mag, r;
    @(negedge i_sclk);
    i_rstn = rst_n; i_valid = vld; i_tdata = 29'(x); i_relu_en = relu;
    i_vsync = vs; i_hsync = hs; i_reuse = ru;
    i_cfg_we = we; i_cfg_addr = 2'(addr); i_cfg_a = 20'(wa); i_cfg_b = 32'(wb);
    if (!rst_n) begin
      q.delete();
      mch = 0;
      for (int i = 0; i < 4; i++) begin ma[i] = 0; mb[i] = 0; end
    end else begin
      cur = vs ? 0 : mch;
      if (vld) begin
        p = x * ma[cur] + mb[cur];
        mag = p < 0 ? -p : p;
        r = (mag + 32768) / 65536;
        if (p < 0) r = -r;
        e.s = 1'b0;
        if (r > 511) begin r = 511; e.s = 1'b1; end
        else if (r < -512) begin r = -512; e.s = 1'b1; end
        if (relu && r < 0) begin r = 0; e.s = 1'b0; end
        e.d = 10'(r); e.ch = 2'(cur); e.vs = vs; e.hs = hs; e.ru = ru; e.due = cyc + 3;
        q.push_back(e);
        mch = (cur + 1) % 4;
      end else if (vs) mch = 0;
      if (we) begin ma[addr] = wa; mb[addr] = wb; end
    end
    @(posedge i_sclk);
    cyc++;
    #1;
    if (!rst_n) last = '0;
    n_tests++;
    if (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (o_valid !== 1'b1 || o_tdata !== e.d || o_sat !== e.s || o_ch !== e.ch ||
          o_vsync !== e.vs || o_hsync !== e.hs || o_reuse !== e.ru) begin
        n_fail++;
        $display("FAIL sample@%0d: got valid=%b data=%0d sat=%b ch=%0d vs/hs/ru=%b%b%b, want valid=1 data=%0d sat=%b ch=%0d vs/hs/ru=%b%b%b",
                 cyc, o_valid, o_tdata, o_sat, o_ch, o_vsync, o_hsync, o_reuse, e.d, e.s, e.ch, e.vs, e.hs, e.ru);
      end
      last = e.d;
    end else if (o_valid !== 1'b0 || o_sat !== 1'b0 || o_tdata !== last) begin
      n_fail++;
      $display("FAIL idle@%0d: got valid=%b sat=%b data=%0d, want valid=0 sat=0 data=%0d",
               cyc, o_valid, o_sat, o_tdata, last);
    end
  endtask
  task automatic smp(input longint x, input bit relu, input bit vs);
    step(1, 1, x, relu, vs, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic idle(input int n);
    repeat (n) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic cfg(input int addr, input longint a, input longint b);
    step(1, 0, 0, 0, 0, 0, 0, 1, addr, a, b);
  endtask
  task automatic test_reset;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({o_vsync, o_hsync, o_reuse, o_valid, o_sat} !== 5'b0 || o_tdata !== 10'sd0 || o_ch !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got sb=%b%b%b%b sat=%b data=%0d ch=%0d, want all 0",
               o_vsync, o_hsync, o_reuse, o_valid, o_sat, o_tdata, o_ch);
    end
  endtask
  task automatic test_identity;
    cfg(0, 65536, 0);
    smp(100, 0, 1);
    smp(-100, 0, 1);
    idle(3);
  endtask
  task automatic test_scale;
    cfg(0, 32768, 0);
    smp(3, 0, 1);
    smp(-3, 0, 1);
    smp(2, 0, 1);
    cfg(0, 98304, 32768);
    smp(100, 0, 1);
    idle(3);
  endtask
  task automatic test_sat;
    cfg(0, 65536, 0);
    smp(600, 0, 1);
    smp(-600, 0, 1);
    smp(511, 0, 1);
    smp(-512, 0, 1);
    idle(3);
  endtask
  task automatic test_relu;
    smp(-5, 1, 1);
    smp(-600, 1, 1);
    smp(7, 1, 1);
    smp(-9, 0, 1);
    smp(-9, 1, 1);
    smp(-9, 0, 1);
    smp(600, 1, 1);
    idle(3);
  endtask
  task automatic test_interleave;
    for (int c = 0; c < 4; c++) cfg(c, (c + 1) * 65536, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 10, 0, 0, i == 2, i == 5, 0, 0, 0, 0);
      if (i % 3 == 1) idle(1);
    end
    smp(10, 0, 0);
    smp(10, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    smp(10, 0, 0);
    smp(10, 0, 0);
    smp(10, 0, 1);
    smp(10, 0, 0);
    idle(3);
  endtask
  task automatic test_cfg_race;
    for (int c = 0; c < 4; c++) cfg(c, 65536, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    smp(10, 0, 0);
    step(1, 1, 10, 0, 0, 0, 0, 1, 1, 3 * 65536, 0);
    smp(10, 0, 0);
    smp(10, 0, 0);
    smp(10, 0, 0);
    smp(10, 0, 0);
    idle(3);
  endtask
  task automatic test_reset_mid;
    smp(10, 0, 0);
    smp(20, 0, 0);
    step(0, 1, 30, 0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({o_vsync, o_hsync, o_reuse, o_valid, o_sat} !== 5'b0 || o_tdata !== 10'sd0 || o_ch !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_midstream: got sb=%b%b%b%b sat=%b data=%0d ch=%0d, want all 0",
               o_vsync, o_hsync, o_reuse, o_valid, o_sat, o_tdata, o_ch);
    end
    idle(3);
    smp(100, 0, 0);
    smp(-100, 0, 0);
    idle(3);
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin ma[i] = 0; mb[i] = 0; end
    test_reset;
    test_identity;
    test_scale;
    test_sat;
    test_relu;
    test_interleave;
    test_cfg_race;
    test_reset_mid;
    idle(4);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pending: got %0d samples never output, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
